// File: rtl/ndn_pkg.sv
// ----------------------------------------------------------------------------
// ndn_pkg
// Shared definitions for the PIT packet RAM:
//   - default geometry (slot count / bytes per slot as log2 values)
//   - stream replay FSM state encoding
//   - range helpers for PIT addresses and byte offsets
// ----------------------------------------------------------------------------
package ndn_pkg;

   localparam int SLOT_BITS_DEF = 4;   // 16 slots
   localparam int OFF_BITS_DEF  = 6;   // 64 bytes per slot
   localparam int ADDR_W_DEF    = 10;
   localparam int BYTE_W_DEF    = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } stream_st_e;

   // Slot index is valid when it addresses one of the 2**slot_bits slots.
   function automatic logic slot_ok(input logic [31:0] a, input int slot_bits);
      return a < (32'd1 << slot_bits);
   endfunction

   // Both the slot and the byte offset must land inside the store.
   function automatic logic in_range(input logic [31:0] a, input logic [31:0] b,
                                     input int slot_bits, input int off_bits);
      return (a < (32'd1 << slot_bits)) && (b < (32'd1 << off_bits));
   endfunction

endpackage

// File: rtl/pit_slot_mem.sv
// ----------------------------------------------------------------------------
// pit_slot_mem
// Plain synchronous single-port byte array, read-first, 1-cycle read latency.
// Only the read register is reset; the storage itself is not.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (read register only)
//   en_i            access enable (read always happens when enabled)
//   we_i            write enable (qualified by en_i)
//   addr_i          word address
//   wdata_i         write data
//   rdata_o         registered read data (old contents on a same-cycle write)
// ----------------------------------------------------------------------------
module pit_slot_mem #(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i && we_i) mem_q[addr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   rdata_q <= '0;
      else if (en_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pit_packet_ram.sv
// ----------------------------------------------------------------------------
// pit_packet_ram
// Slotted packet byte store behind the PIT RAM interface, with per-slot
// valid/length bookkeeping and a replay engine that streams one stored packet
// over a valid/ready byte interface.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   wr_data_i            write byte
//   addr_i               slot address (also selects slot_len_o)
//   current_byte_i       byte offset inside the slot
//   write_enable_i       write strobe
//   read_data_o          host read byte, 1-cycle latency, holds when port busy
//   clear_en_i/addr_i    invalidate a slot
//   slot_len_o           stored length of slot addr_i
//   occupancy_o          number of valid slots
//   overflow_o           sticky: out-of-range write dropped
//   stream_*             replay request and byte stream
// One memory access per cycle: write > stream fetch > host read.
// ----------------------------------------------------------------------------
module pit_packet_ram import ndn_pkg::*; #(
   parameter int SLOT_BITS = SLOT_BITS_DEF,
   parameter int OFF_BITS  = OFF_BITS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int BYTE_W    = BYTE_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [7:0]           wr_data_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [BYTE_W-1:0]    current_byte_i,
   input  logic                 write_enable_i,
   output logic [7:0]           read_data_o,
   input  logic                 clear_en_i,
   input  logic [ADDR_W-1:0]    clear_addr_i,
   output logic [OFF_BITS:0]    slot_len_o,
   output logic [SLOT_BITS:0]   occupancy_o,
   output logic                 overflow_o,
   input  logic                 stream_start_i,
   input  logic [ADDR_W-1:0]    stream_slot_i,
   output logic [7:0]           stream_data_o,
   output logic                 stream_valid_o,
   input  logic                 stream_ready_i,
   output logic                 stream_last_o,
   output logic                 stream_busy_o,
   output logic                 stream_err_o
);

   localparam int SLOTS = 2**SLOT_BITS;
   localparam int MAW   = SLOT_BITS + OFF_BITS;

   // ---------------------------------------------------------------- decode
   logic [SLOT_BITS-1:0] wslot, cslot, sslot;
   logic [OFF_BITS-1:0]  woff;
   logic                 acc_ok, addr_ok, clr_ok, sslot_ok, wr_ok;

   assign wslot    = addr_i[SLOT_BITS-1:0];
   assign woff     = current_byte_i[OFF_BITS-1:0];
   assign cslot    = clear_addr_i[SLOT_BITS-1:0];
   assign sslot    = stream_slot_i[SLOT_BITS-1:0];
   assign acc_ok   = in_range(32'(addr_i), 32'(current_byte_i), SLOT_BITS, OFF_BITS);
   assign addr_ok  = slot_ok(32'(addr_i), SLOT_BITS);
   assign clr_ok   = clear_en_i && slot_ok(32'(clear_addr_i), SLOT_BITS);
   assign sslot_ok = slot_ok(32'(stream_slot_i), SLOT_BITS);
   assign wr_ok    = write_enable_i && acc_ok;

   // ---------------------------------------------------------------- state
   stream_st_e                     state_q, state_d;
   logic [SLOT_BITS-1:0]           slot_q, slot_d;
   logic [OFF_BITS:0]              plen_q, plen_d;
   logic [OFF_BITS-1:0]            idx_q, idx_d;
   logic                           err_q, err_d;
   logic [SLOTS-1:0]               valid_q, valid_d;
   logic [SLOTS-1:0][OFF_BITS:0]   len_q, len_d;
   logic [SLOT_BITS:0]             occ_q, occ_d;
   logic                           ovf_q, ovf_d;
   logic                           hrd_q, hoor_q, fetch_q;
   logic [7:0]                     rd_hold_q, sd_hold_q;

   // ---------------------------------------------------------------- port arbitration
   // Any write strobe owns the port, even an out-of-range one that is dropped,
   // so fetch stalls and host reads hold whenever write_enable_i is high.
   logic           fetch_go, host_go, mem_en;
   logic [MAW-1:0] mem_addr;
   logic [7:0]     mem_rdata;

   assign fetch_go = (state_q == ST_FETCH) && !write_enable_i;
   assign host_go  = !write_enable_i && !fetch_go;
   assign mem_en   = wr_ok || fetch_go || host_go;
   assign mem_addr = fetch_go ? {slot_q, idx_q} : {wslot, woff};

   pit_slot_mem #(.AW(MAW), .DW(8)) u_mem (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (mem_en),
      .we_i    (wr_ok),
      .addr_i  (mem_addr),
      .wdata_i (wr_data_i),
      .rdata_o (mem_rdata)
   );

   // The memory read register is shared, so each consumer keeps its own copy:
   // the fresh value is forwarded the cycle after its own access, and the
   // held copy is shown otherwise.
   assign read_data_o   = hrd_q ? (hoor_q ? 8'h00 : mem_rdata) : rd_hold_q;
   assign stream_data_o = fetch_q ? mem_rdata : sd_hold_q;

   // ---------------------------------------------------------------- bookkeeping
   logic [OFF_BITS:0] wlen;
   assign wlen = (OFF_BITS+1)'(woff) + (OFF_BITS+1)'(1);

   // Clear is applied before the write so a same-cycle clear+write of one
   // slot leaves it valid with just the new byte counted.
   always_comb begin
      valid_d = valid_q;
      len_d   = len_q;
      ovf_d   = ovf_q || (write_enable_i && !acc_ok);
      if (clr_ok) begin
         valid_d[cslot] = 1'b0;
         len_d[cslot]   = '0;
      end
      if (wr_ok) begin
         valid_d[wslot] = 1'b1;
         if (wlen > len_d[wslot]) len_d[wslot] = wlen;
      end
      occ_d = '0;
      for (int i = 0; i < SLOTS; i++) occ_d = occ_d + (SLOT_BITS+1)'(valid_d[i]);
   end

   assign slot_len_o  = addr_ok ? len_q[wslot] : '0;
   assign occupancy_o = occ_q;
   assign overflow_o  = ovf_q;

   // ---------------------------------------------------------------- stream FSM
   logic last, abort, start_ok;

   assign last     = ({1'b0, idx_q} == (plen_q - (OFF_BITS+1)'(1)));
   assign abort    = clr_ok && (cslot == slot_q);
   assign start_ok = sslot_ok && valid_q[sslot] && (len_q[sslot] != '0);

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      plen_d  = plen_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (stream_start_i) begin
               if (start_ok) begin
                  slot_d  = sslot;
                  plen_d  = len_q[sslot];   // frozen for the whole replay
                  idx_d   = '0;
                  state_d = ST_FETCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            if (abort) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (!write_enable_i) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (stream_ready_i) begin
               if (last) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + OFF_BITS'(1);
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign stream_valid_o = (state_q == ST_SEND);
   assign stream_last_o  = (state_q == ST_SEND) && last;
   assign stream_busy_o  = (state_q != ST_IDLE);
   assign stream_err_o   = err_q;

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         slot_q    <= '0;
         plen_q    <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         valid_q   <= '0;
         len_q     <= '0;
         occ_q     <= '0;
         ovf_q     <= 1'b0;
         hrd_q     <= 1'b0;
         hoor_q    <= 1'b0;
         fetch_q   <= 1'b0;
         rd_hold_q <= '0;
         sd_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         plen_q    <= plen_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         len_q     <= len_d;
         occ_q     <= occ_d;
         ovf_q     <= ovf_d;
         hrd_q     <= host_go;
         hoor_q    <= !acc_ok;
         fetch_q   <= fetch_go;
         rd_hold_q <= read_data_o;
         sd_hold_q <= stream_data_o;
      end
   end

endmodule

// File: tb/tb_pit_packet_ram.sv
// ----------------------------------------------------------------------------
// tb_pit_packet_ram
// Directed stimulus against a behavioural model of the packet store (plain
// arrays per slot/byte, a replay cursor) compared every cycle, plus literal
// expectations for the headline scenarios.
// ----------------------------------------------------------------------------
module tb_pit_packet_ram;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wr_data = '0;
   logic [9:0] addr = '0, cb = '0, clear_addr = '0, sslot = '0;
   logic       we = 1'b0, clear_en = 1'b0, start = 1'b0, ready = 1'b0;
   logic [7:0] read_data, sdata;
   logic [6:0] slot_len;
   logic [4:0] occupancy;
   logic       overflow, svalid, slast, sbusy, serr;

   always #5 clk = ~clk;

   pit_packet_ram dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_data_i(wr_data), .addr_i(addr),
      .current_byte_i(cb), .write_enable_i(we), .read_data_o(read_data),
      .clear_en_i(clear_en), .clear_addr_i(clear_addr), .slot_len_o(slot_len),
      .occupancy_o(occupancy), .overflow_o(overflow), .stream_start_i(start),
      .stream_slot_i(sslot), .stream_data_o(sdata), .stream_valid_o(svalid),
      .stream_ready_i(ready), .stream_last_o(slast), .stream_busy_o(sbusy),
      .stream_err_o(serr)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [7:0] mem_m [16][64];
   bit         wk_m  [16][64];     // location has been written at least once
   bit         val_m [16];
   int         len_m [16];
   bit         ovf_m, rd_k, sd_k, err_m;
   logic [7:0] rd_m, sd_m;
   int         st_m;               // 0 idle, 1 waiting to fetch, 2 offering byte
   int         sl_m, ix_m, pl_m;

   initial forever begin : model
      int a, b, c, s;
      bit inr, cl, fetch, host, abort;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin val_m[i] = 0; len_m[i] = 0; end
         ovf_m = 0; rd_m = 0; rd_k = 1; sd_m = 0; sd_k = 1;
         st_m = 0; err_m = 0; sl_m = 0; ix_m = 0; pl_m = 0;
      end else begin
         a = int'(addr); b = int'(cb); c = int'(clear_addr); s = int'(sslot);
         inr   = (a < 16) && (b < 64);
         cl    = clear_en && (c < 16);
         fetch = (st_m == 1) && !we;
         host  = !we && !fetch;
         abort = (st_m != 0) && cl && (c == sl_m);
         if (host) begin
            if (inr) begin rd_m = mem_m[a][b]; rd_k = wk_m[a][b]; end
            else begin rd_m = 8'h00; rd_k = 1; end
         end
         if (fetch) begin sd_m = mem_m[sl_m][ix_m]; sd_k = wk_m[sl_m][ix_m]; end
         err_m = 0;
         if (st_m == 0) begin
            if (start) begin
               if (s < 16 && val_m[s] && len_m[s] > 0) begin
                  st_m = 1; sl_m = s; ix_m = 0; pl_m = len_m[s];
               end else err_m = 1;
            end
         end else if (abort) begin
            st_m = 0; err_m = 1;
         end else if (st_m == 1) begin
            if (!we) st_m = 2;
         end else if (ready) begin
            if (ix_m == pl_m - 1) st_m = 0;
            else begin ix_m++; st_m = 1; end
         end
         if (cl) begin val_m[c] = 0; len_m[c] = 0; end
         if (we) begin
            if (inr) begin
               mem_m[a][b] = wr_data; wk_m[a][b] = 1; val_m[a] = 1;
               if (b + 1 > len_m[a]) len_m[a] = b + 1;
            end else ovf_m = 1;
         end
      end
   end

   // ---------------------------------------------------------------- compare
   logic [7:0] got_d[$];
   bit         got_l[$];

   initial forever begin : cmp
      int ocnt, elen;
      @(negedge clk);
      if (rst_n) begin
         ocnt = 0;
         for (int i = 0; i < 16; i++) ocnt += int'(val_m[i]);
         elen = (addr < 10'd16) ? len_m[int'(addr[3:0])] : 0;
         if (rd_k) chk("m_read_data", 32'(read_data), 32'(rd_m));
         chk("m_slot_len", 32'(slot_len), 32'(elen));
         chk("m_occupancy", 32'(occupancy), 32'(ocnt));
         chk("m_overflow", 32'(overflow), 32'(ovf_m));
         chk("m_busy", 32'(sbusy), 32'(st_m != 0));
         chk("m_valid", 32'(svalid), 32'(st_m == 2));
         chk("m_last", 32'(slast), 32'(st_m == 2 && ix_m == pl_m - 1));
         chk("m_err", 32'(serr), 32'(err_m));
         if (st_m == 2 && sd_k) chk("m_stream_data", 32'(sdata), 32'(sd_m));
         if (svalid && ready) begin got_d.push_back(sdata); got_l.push_back(slast); end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic tick(); @(posedge clk); #2; endtask
   task automatic set_rw(input int s, input int b); addr = 10'(s); cb = 10'(b); endtask
   task automatic wr(input int s, input int b, input logic [7:0] d);
      set_rw(s, b); wr_data = d; we = 1'b1; tick(); we = 1'b0;
   endtask
   task automatic begin_stream(input int s);
      sslot = 10'(s); start = 1'b1; tick(); start = 1'b0;
   endtask
   task automatic wait_valid(input string nm);
      int n = 0;
      while (!svalid && n < 20) begin tick(); n++; end
      chk(nm, 32'(svalid), 1);
   endtask
   task automatic wait_idle(input string nm);
      int n = 0;
      while (sbusy && n < 40) begin tick(); n++; end
      chk(nm, 32'(sbusy), 0);
   endtask
   task automatic chk_pkt(input string nm);
      chk({nm, "_count"}, 32'(got_d.size()), 3);
      if (got_d.size() == 3) begin
         chk({nm, "_bytes"}, {8'h0, got_d[0], got_d[1], got_d[2]}, 32'h00A1B2C3);
         chk({nm, "_lastflags"}, 32'({got_l[0], got_l[1], got_l[2]}), 32'b001);
      end
   endtask
   task automatic chk_all_zero(input string nm);
      chk({nm, "_outs"}, 32'({read_data, sdata, svalid, slast, sbusy, serr, overflow}), 0);
      chk({nm, "_occ_len"}, 32'({occupancy, slot_len}), 0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // basic write / read / bookkeeping
      wr(3, 0, 8'hA1); wr(3, 1, 8'hB2); wr(3, 2, 8'hC3);
      set_rw(3, 1); tick();
      chk("rd_b2", 32'(read_data), 32'hB2);
      chk("len3", 32'(slot_len), 3);
      chk("occ1", 32'(occupancy), 1);

      // out-of-range accesses
      wr(20, 0, 8'h55);
      chk("ovf_set", 32'(overflow), 1);
      wr(3, 64, 8'h66);
      chk("ovf_sticky", 32'(overflow), 1);
      set_rw(20, 0); tick();
      chk("rd_oor_slot", 32'(read_data), 0);
      set_rw(3, 64); tick();
      chk("rd_oor_byte", 32'(read_data), 0);
      chk("occ_after_oor", 32'(occupancy), 1);

      // full-rate replay of slot 3
      got_d.delete(); got_l.delete();
      ready = 1'b1;
      begin_stream(3);
      wait_idle("s1_done");
      chk_pkt("s1");

      // replay with back-pressure and a length-extending write mid-packet
      got_d.delete(); got_l.delete();
      ready = 1'b0;
      begin_stream(3);
      wait_valid("s2_first");
      ready = 1'b1; tick(); ready = 1'b0;
      wait_valid("s2_second");
      wr(3, 3, 8'hD4);
      repeat (4) tick();
      chk("s2_hold_data", 32'(sdata), 32'hB2);
      chk("s2_hold_valid", 32'(svalid), 1);
      ready = 1'b1;
      wait_idle("s2_done");
      ready = 1'b0;
      chk_pkt("s2");
      set_rw(3, 0); tick();
      chk("len_extended", 32'(slot_len), 4);

      // start on an empty slot
      begin_stream(7);
      chk("bad_start_err", 32'(serr), 1);
      chk("bad_start_busy", 32'(sbusy), 0);
      tick();
      chk("bad_start_err_clr", 32'(serr), 0);

      // clear of the active slot aborts the replay
      begin_stream(3);
      wait_valid("ab_valid");
      clear_addr = 10'd3; clear_en = 1'b1; tick(); clear_en = 1'b0;
      chk("ab_valid_drop", 32'(svalid), 0);
      chk("ab_err", 32'(serr), 1);
      chk("ab_occ", 32'(occupancy), 0);
      chk("ab_len", 32'(slot_len), 0);
      tick();

      // same-cycle clear + write: invalid slot, then already-valid slot
      clear_addr = 10'd5; clear_en = 1'b1;
      wr(5, 4, 8'h5A); clear_en = 1'b0;
      chk("cw1_len", 32'(slot_len), 5);
      chk("cw1_occ", 32'(occupancy), 1);
      wr(5, 9, 8'h59);
      chk("cw2_pre_len", 32'(slot_len), 10);
      clear_en = 1'b1;
      wr(5, 4, 8'h5B); clear_en = 1'b0;
      chk("cw2_len", 32'(slot_len), 5);
      chk("cw2_occ", 32'(occupancy), 1);

      // asynchronous reset in the middle of a replay
      wr(2, 0, 8'h21); wr(2, 1, 8'h22);
      begin_stream(2);
      wait_valid("ar_valid");
      #1 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      wr(1, 0, 8'h77);
      set_rw(1, 0); tick();
      chk("post_rst_rd", 32'(read_data), 32'h77);
      chk("post_rst_occ", 32'(occupancy), 1);
      chk("post_rst_len", 32'(slot_len), 1);
      chk("post_rst_ovf", 32'(overflow), 0);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
